// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks a low row across the keypad, debounces press
// and release, and holds one {row, col} code with a level key_press per physical press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 24000,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_row_n,
    output logic [3:0] key_col_n,
    output logic       key_press,
    output logic [1:0] o_dbg_state
);
    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_cand_row;
    logic [3:0]    r_cand_col;
    logic [DW-1:0] r_dwell;
    logic [BW-1:0] r_deb;

    logic [3:0]    w_col_s;
    logic [3:0]    w_row_next;
    logic [2:0]    w_low_cnt;
    logic          w_one_low;
    logic          w_col_idle;

    assign w_col_s    = r_sync2;
    assign w_row_next = {row_n[2:0], row_n[3]};
    assign w_col_idle = (w_col_s == 4'b1111);
    assign w_low_cnt  = {2'b00, ~w_col_s[0]} + {2'b00, ~w_col_s[1]}
                      + {2'b00, ~w_col_s[2]} + {2'b00, ~w_col_s[3]};
    // Two or more low columns is a ghosting/rollover pattern and is never a candidate.
    assign w_one_low  = (w_low_cnt == 3'd1);

    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= SCAN;
            row_n      <= 4'b1110;
            key_row_n  <= 4'b1111;
            key_col_n  <= 4'b1111;
            key_press  <= 1'b0;
            r_sync1    <= 4'b1111;
            r_sync2    <= 4'b1111;
            r_cand_row <= 4'b1111;
            r_cand_col <= 4'b1111;
            r_dwell    <= '0;
            r_deb      <= '0;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
            case (r_state)
                SCAN: begin
                    if (r_dwell != DWELL_LAST) begin
                        r_dwell <= r_dwell + DW'(1);
                    end else if (w_one_low) begin
                        r_cand_row <= row_n;
                        r_cand_col <= w_col_s;
                        r_deb      <= '0;
                        r_state    <= DEBOUNCE;
                    end else begin
                        row_n   <= w_row_next;
                        r_dwell <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (w_col_s != r_cand_col) begin
                        row_n   <= w_row_next;
                        r_dwell <= '0;
                        r_state <= SCAN;
                    end else if (r_deb == DEB_LAST) begin
                        key_row_n <= r_cand_row;
                        key_col_n <= r_cand_col;
                        key_press <= 1'b1;
                        r_state   <= HELD;
                    end else begin
                        r_deb <= r_deb + BW'(1);
                    end
                end
                HELD: begin
                    if (w_col_idle) begin
                        r_deb   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A bounce back to any low column keeps key_press high.
                    if (!w_col_idle) begin
                        r_state <= HELD;
                    end else if (r_deb == DEB_LAST) begin
                        key_press <= 1'b0;
                        row_n     <= w_row_next;
                        r_dwell   <= '0;
                        r_state   <= SCAN;
                    end else begin
                        r_deb <= r_deb + BW'(1);
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model plus a timeline model that
// predicts every output per cycle from scan windows, sync delay and debounce length.
module tb_keypad_scan_ctrl;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int NEVER    = 1 << 30;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_row_n;
    logic [3:0] key_col_n;
    logic       key_press;
    logic [1:0] dbg_state;

    bit   pressed [4][4];
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;

    // Scan timeline: row index m_r0 is driven from edge m_s0 with a fresh dwell count.
    int         m_s0;
    int         m_r0;
    logic [3:0] m_krow;
    logic [3:0] m_kcol;

    keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_row_n  (key_row_n),
        .key_col_n  (key_col_n),
        .key_press  (key_press),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                if (((row_n >> r) & 4'b0001) == 4'b0000 && pressed[2'(r)][2'(j)])
                    col_n = col_n & ~(4'b0001 << j);
    end

    function automatic logic [3:0] low_at(input int i);
        return ~(4'b0001 << i);
    endfunction

    function automatic int scan_row(input int s0, input int r0, input int n);
        return (r0 + (n - s0) / SCAN_DIV) % 4;
    endfunction

    // First end-of-window edge for row r at or after min_d.
    function automatic int next_dec(input int r, input int min_d);
        int j;
        j = 1;
        while (!(((m_r0 + j - 1) % 4 == r) && (m_s0 + SCAN_DIV * j >= min_d))) j++;
        return m_s0 + SCAN_DIV * j;
    endfunction

    task automatic set_key(input int r, input int c, input bit v);
        pressed[2'(r)][2'(c)] = v;
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[2'(r)][2'(c)] = 1'b0;
    endtask

    // Press key (r,c) for L cycles (L<0: leave it held), timed to land o cycles
    // before the row's window closes; optional bounce or extra keys while held.
    task automatic run_key(input int r, input int c, input int L, input int o,
                           input bit already, input bit bounce, input bit extra,
                           input string tag);
        int p, d, rise, rel, stop, last, r2, c2, c3, e_row;
        bit acc;
        logic e_press;
        logic [3:0] e_krow, e_kcol;
        p = edge_n;
        d = next_dec(r, already ? p + 3 : p + 13);
        if (!already) p = d - 3 - o;
        rise = d + DEB;
        acc  = (L < 0) || (p + L >= d + DEB - 2);
        rel  = (L < 0) ? NEVER : p + L;
        stop = (L < 0) ? NEVER : (acc ? rel + 3 + DEB : rel + 3);
        last = (L < 0) ? rise + 6 : stop + 4;
        r2 = (r + 1 + int'($urandom_range(0, 2))) % 4;
        c2 = int'($urandom_range(0, 3));
        c3 = (c + 1 + int'($urandom_range(0, 2))) % 4;
        while (edge_n < last) begin
            if (!already && edge_n == p) set_key(r, c, 1'b1);
            if (acc && bounce && edge_n == rise + 2) set_key(r, c, 1'b0);
            if (acc && bounce && edge_n == rise + 5) set_key(r, c, 1'b1);
            if (acc && extra && edge_n == rise + 1) begin
                set_key(r2, c2, 1'b1);
                set_key(r, c3, 1'b1);
            end
            if (edge_n == rel) clear_keys();
            @(posedge clk); #1;
            if (edge_n < d)          e_row = scan_row(m_s0, m_r0, edge_n);
            else if (edge_n < stop)  e_row = r;
            else                     e_row = scan_row(stop, (r + 1) % 4, edge_n);
            e_press = acc && edge_n >= rise && edge_n < stop;
            e_krow  = (acc && edge_n >= rise) ? low_at(r) : m_krow;
            e_kcol  = (acc && edge_n >= rise) ? low_at(c) : m_kcol;
            checks++;
            if (row_n !== low_at(e_row)) begin
                failures++;
                $display("FAIL %s row_n edge=%0d got=%b exp=%b", tag, edge_n, row_n, low_at(e_row));
            end
            checks++;
            if (key_press !== e_press) begin
                failures++;
                $display("FAIL %s key_press edge=%0d got=%b exp=%b", tag, edge_n, key_press, e_press);
            end
            checks++;
            if (key_row_n !== e_krow) begin
                failures++;
                $display("FAIL %s key_row_n edge=%0d got=%b exp=%b", tag, edge_n, key_row_n, e_krow);
            end
            checks++;
            if (key_col_n !== e_kcol) begin
                failures++;
                $display("FAIL %s key_col_n edge=%0d got=%b exp=%b", tag, edge_n, key_col_n, e_kcol);
            end
        end
        if (L >= 0) begin
            m_s0 = stop;
            m_r0 = (r + 1) % 4;
        end
        if (acc) begin
            m_krow = low_at(r);
            m_kcol = low_at(c);
        end
    endtask

    task automatic test_reset();
        clear_keys();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (row_n !== 4'b1110) begin
                failures++;
                $display("FAIL reset row_n cycle=%0d got=%b exp=1110", i, row_n);
            end
            checks++;
            if (key_row_n !== 4'b1111) begin
                failures++;
                $display("FAIL reset key_row_n cycle=%0d got=%b exp=1111", i, key_row_n);
            end
            checks++;
            if (key_col_n !== 4'b1111) begin
                failures++;
                $display("FAIL reset key_col_n cycle=%0d got=%b exp=1111", i, key_col_n);
            end
            checks++;
            if (key_press !== 1'b0) begin
                failures++;
                $display("FAIL reset key_press cycle=%0d got=%b exp=0", i, key_press);
            end
        end
        reset  = 1'b1;
        m_s0   = edge_n;
        m_r0   = 0;
        m_krow = 4'b1111;
        m_kcol = 4'b1111;
    endtask

    task automatic test_scan_rotation();
        logic [3:0] e_row;
        for (int i = 0; i < 5 * SCAN_DIV; i++) begin
            @(posedge clk); #1;
            e_row = low_at(scan_row(m_s0, m_r0, edge_n));
            checks++;
            if (row_n !== e_row) begin
                failures++;
                $display("FAIL scan row_n edge=%0d got=%b exp=%b", edge_n, row_n, e_row);
            end
            checks++;
            if (key_press !== 1'b0) begin
                failures++;
                $display("FAIL scan key_press edge=%0d got=%b exp=0", edge_n, key_press);
            end
        end
    endtask

    task automatic test_press_hold();
        run_key(2, 1, 30, int'($urandom_range(0, 9)), 1'b0, 1'b0, 1'b0, "press_hold");
    endtask

    task automatic test_short_press();
        run_key(2, 0, 5, int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0, "short_press");
    endtask

    task automatic test_bounce();
        run_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 40,
                int'($urandom_range(0, 9)), 1'b0, 1'b1, 1'b0, "bounce");
    endtask

    task automatic test_two_columns();
        int r, c, c2;
        logic [3:0] e_row;
        r  = int'($urandom_range(0, 3));
        c  = int'($urandom_range(0, 3));
        c2 = (c + 1 + int'($urandom_range(0, 2))) % 4;
        set_key(r, c, 1'b1);
        set_key(r, c2, 1'b1);
        for (int i = 0; i < 28; i++) begin
            if (i == 24) clear_keys();
            @(posedge clk); #1;
            e_row = low_at(scan_row(m_s0, m_r0, edge_n));
            checks++;
            if (row_n !== e_row) begin
                failures++;
                $display("FAIL two_col row_n edge=%0d got=%b exp=%b", edge_n, row_n, e_row);
            end
            checks++;
            if (key_press !== 1'b0) begin
                failures++;
                $display("FAIL two_col key_press edge=%0d got=%b exp=0", edge_n, key_press);
            end
            checks++;
            if (key_row_n !== m_krow || key_col_n !== m_kcol) begin
                failures++;
                $display("FAIL two_col key_code edge=%0d got=%b/%b exp=%b/%b",
                         edge_n, key_row_n, key_col_n, m_krow, m_kcol);
            end
        end
    endtask

    task automatic test_extra_keys_held();
        run_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 35,
                int'($urandom_range(0, 9)), 1'b0, 1'b0, 1'b1, "extra_held");
    endtask

    task automatic test_reset_held();
        int r, c;
        r = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        run_key(r, c, -1, int'($urandom_range(0, 9)), 1'b0, 1'b0, 1'b0, "held_pre");
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (key_press !== 1'b0) begin
            failures++;
            $display("FAIL held_reset key_press got=%b exp=0", key_press);
        end
        checks++;
        if (row_n !== 4'b1110) begin
            failures++;
            $display("FAIL held_reset row_n got=%b exp=1110", row_n);
        end
        checks++;
        if (key_row_n !== 4'b1111 || key_col_n !== 4'b1111) begin
            failures++;
            $display("FAIL held_reset key_code got=%b/%b exp=1111/1111", key_row_n, key_col_n);
        end
        reset  = 1'b1;
        m_s0   = edge_n;
        m_r0   = 0;
        m_krow = 4'b1111;
        m_kcol = 4'b1111;
        run_key(r, c, 30, 0, 1'b1, 1'b0, 1'b0, "held_reaccept");
    endtask

    task automatic test_random_presses();
        int len, off;
        for (int k = 0; k < 12; k++) begin
            len = int'($urandom_range(1, 30));
            off = int'($urandom_range(0, (len - 1 < 9) ? len - 1 : 9));
            run_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), len, off,
                    1'b0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_scan_rotation();
        test_press_hold();
        test_short_press();
        test_bounce();
        test_two_columns();
        test_extra_keys_held();
        test_random_presses();
        test_reset_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
